fetch_decode: RTL and testbench
===============================

Name: fetch_decode

Overview:
- Instruction fetch/decode stage sitting directly upstream of datapath.
- Holds the PC and fetches 32-bit RISC-V words over a req/valid instruction-memory handshake.
- Decodes R-type ADD/SUB/AND/OR/DIV and BEQ into the datapath controls rs1, rs2, rw, operation and write.
- Resolves BEQ using the datapath's zero_flag; halts on any unsupported encoding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and instruction-memory address width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  ADDR_W  byte address of fetch; equals pc.
- imem_rdata  in  32  instruction word, valid when imem_valid=1.
- imem_valid  in  1  response strobe; accepted only in FETCH with imem_req=1.
- rs1  out  5  datapath source register 1.
- rs2  out  5  datapath source register 2.
- rw  out  5  datapath destination register.
- operation  out  5  ALU operation code from shared constants (ADD, SUB, AND, OR, DIV).
- write  out  1  register-file write enable, one-cycle pulse per R-type issue.
- zero_flag  in  1  datapath ALU zero result for the current rs1/rs2/operation.
- pc  out  ADDR_W  current program counter.
- halted  out  1  sticky; set on illegal instruction or misaligned branch target.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, state=IDLE, imem_req=0, rs1=rs2=rw=0, operation=ADD, write=0, halted=0.
- All outputs are registered.
- FSM states: IDLE, FETCH, DECODE, EXEC, BRANCH, HALT.
- IDLE: first edge after reset release goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_valid=1, latch imem_rdata into the instruction register and go to DECODE.
  - A same-cycle response is allowed. Wait states are unbounded.
- DECODE: register rs1=ir[19:15], rs2=ir[24:20], rw=ir[11:7].
  - opcode 0110011 with (funct7,funct3) of 0000000/000 gives ADD, 0100000/000 gives SUB, 0000000/111 gives AND, 0000000/110 gives OR, 0000001/100 gives DIV. Next state EXEC.
  - opcode 1100011 with funct3 000 is BEQ: operation=SUB. Next state BRANCH.
  - Any other encoding: next state HALT, halted=1.
- EXEC:
  - write=1 for exactly this cycle, unless rw==0, in which case write=0 (x0 is never written).
  - pc <= pc+4, next state FETCH.
- BRANCH:
  - write=0. zero_flag is sampled at the end of the cycle.
  - Target = pc + sign-extended 13-bit B-immediate {ir[31],ir[7],ir[30:25],ir[11:8],0}, computed modulo 2^ADDR_W (wrap-around permitted).
  - If zero_flag=1: taken. A target with bit1 set goes to HALT with halted=1; otherwise pc <= target.
  - If zero_flag=0: pc <= pc+4.
  - Next state FETCH.
- HALT: terminal. imem_req=0, write=0, pc frozen. Only reset exits.
- Latency: R-type takes at least 3 cycles (FETCH, DECODE, EXEC). BEQ takes at least 3 cycles.
- imem_valid outside FETCH is ignored.
- Reset mid-fetch abandons the outstanding request. A response arriving after reset release, before FETCH is entered, is ignored.
- pc+4 wraps at 2^ADDR_W.

Optional Feature:
- Macro: FETCH_DECODE_RETIRE_CNT_EN.
- Defined: adds output retire_count [31:0], reset to 0.
  - Increments by 1 on each EXEC cycle (including rw==0) and each BRANCH cycle.
  - Wraps at 2^32.
  - Does not increment in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared constants file (the one datapath already uses) holds:
  - ALU operation codes;
  - opcode values OP_R=0110011 and OP_BRANCH=1100011;
  - funct3 and funct7 values;
  - the FSM state encoding.
- One sub-module, instr_decoder: combinational, instruction word in; rs1, rs2, rw, operation, is_r, is_beq, illegal and b_imm out.
- The FSM and PC stay in fetch_decode.

Test Plan:
- Reset, then imem_valid tied to imem_req, imem_rdata=0x002081B3 (ADD x3,x1,x2) -> rs1=1, rs2=2, rw=3, operation=ADD, write pulses for 1 cycle, pc 0 -> 4.
- 0x407302B3 (SUB x5,x6,x7) delivered after 3 wait cycles -> imem_req held 4 cycles, then operation=SUB, rw=5, write single pulse.
- 0x00208463 (BEQ x1,x2,+8) at pc=0x10: zero_flag=1 -> next imem_addr=0x18; zero_flag=0 -> next imem_addr=0x14; write=0 throughout.
- 0x00208033 (ADD x0,x1,x2) -> write stays 0, pc advances by 4.
- 0x00000013 (ADDI) -> halted=1, imem_req=0 and pc frozen for 20 cycles; assert reset=0 -> pc=RESET_PC, halted=0.
- Assert reset=0 during a FETCH wait, pulse imem_valid during reset -> no decode occurs; after release the fetch restarts at RESET_PC. With FETCH_DECODE_RETIRE_CNT_EN, 5 R-types plus 1 BEQ -> retire_count=6.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Constants shared by the fetch/decode stage and the datapath: ALU opcodes,
// RISC-V opcode/funct fields and the fetch FSM state encoding.
package fetch_decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned BIMM_W  = 13;

    localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 5'd3;
    localparam logic [OP_W-1:0] ALU_DIV = 5'd4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_BRANCH,
        ST_HALT
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of the supported R-type ops and BEQ; everything else
// is flagged illegal.
module instr_decoder
    import fetch_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [REG_W-1:0]   rw,
    output logic [OP_W-1:0]    operation,
    output logic               is_r,
    output logic               is_beq,
    output logic               illegal,
    output logic [BIMM_W-1:0]  b_imm
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rw     = instr[11:7];
    assign b_imm  = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    always_comb begin
        operation = ALU_ADD;
        is_r      = 1'b0;
        is_beq    = 1'b0;
        if (opcode == OP_R) begin
            case ({funct7, funct3})
                {F7_BASE, F3_ADD_SUB}:  begin is_r = 1'b1; operation = ALU_ADD; end
                {F7_ALT, F3_ADD_SUB}:   begin is_r = 1'b1; operation = ALU_SUB; end
                {F7_BASE, F3_AND}:      begin is_r = 1'b1; operation = ALU_AND; end
                {F7_BASE, F3_OR}:       begin is_r = 1'b1; operation = ALU_OR;  end
                {F7_MULDIV, F3_DIV}:    begin is_r = 1'b1; operation = ALU_DIV; end
                default:                begin is_r = 1'b0; operation = ALU_ADD; end
            endcase
        end else if (opcode == OP_BRANCH && funct3 == F3_BEQ) begin
            // BEQ compares by subtraction; the datapath reports zero on equality
            is_beq    = 1'b1;
            operation = ALU_SUB;
        end
        illegal = !(is_r || is_beq);
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: PC, instruction fetch handshake and datapath control.
// Optional retire counter enabled by FETCH_DECODE_RETIRE_CNT_EN.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [REG_W-1:0]   rw,
    output logic [OP_W-1:0]    operation,
    output logic               write,
    input  logic               zero_flag,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
`ifdef FETCH_DECODE_RETIRE_CNT_EN
    ,
    output logic [31:0]        retire_count
`endif
);

    state_t             state, state_next;
    logic [INSTR_W-1:0] ir, ir_next;
    logic [ADDR_W-1:0]  pc_next, pc_plus4, br_target;
    logic [REG_W-1:0]   rs1_next, rs2_next, rw_next;
    logic [OP_W-1:0]    operation_next;
    logic               req_next, write_next, halted_next;

    logic [REG_W-1:0]   dec_rs1, dec_rs2, dec_rw;
    logic [OP_W-1:0]    dec_op;
    logic               dec_is_r, dec_is_beq, dec_illegal;
    logic [BIMM_W-1:0]  dec_b_imm;

    instr_decoder u_dec (
        .instr     (ir),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .rw        (dec_rw),
        .operation (dec_op),
        .is_r      (dec_is_r),
        .is_beq    (dec_is_beq),
        .illegal   (dec_illegal),
        .b_imm     (dec_b_imm)
    );

    assign imem_addr = pc;
    assign pc_plus4  = pc + ADDR_W'(4);
    assign br_target = pc + {{(ADDR_W-BIMM_W){dec_b_imm[BIMM_W-1]}}, dec_b_imm};

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        rs1_next       = rs1;
        rs2_next       = rs2;
        rw_next        = rw;
        operation_next = operation;
        write_next     = 1'b0;
        halted_next    = halted;
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_req && imem_valid) begin
                    ir_next    = imem_rdata;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rs1_next       = dec_rs1;
                rs2_next       = dec_rs2;
                rw_next        = dec_rw;
                operation_next = dec_op;
                if (dec_illegal) begin
                    state_next  = ST_HALT;
                    halted_next = 1'b1;
                end else if (dec_is_r) begin
                    state_next = ST_EXEC;
                    write_next = (dec_rw != '0);
                end else begin
                    state_next = ST_BRANCH;
                end
            end
            ST_EXEC: begin
                pc_next    = pc_plus4;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                if (!zero_flag) begin
                    pc_next    = pc_plus4;
                    state_next = ST_FETCH;
                end else if (br_target[1]) begin
                    state_next  = ST_HALT;
                    halted_next = 1'b1;
                end else begin
                    pc_next    = br_target;
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: begin
                state_next  = ST_HALT;
                halted_next = 1'b1;
            end
        endcase
        req_next = (state_next == ST_FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            imem_req  <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rw        <= '0;
            operation <= ALU_ADD;
            write     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            ir        <= ir_next;
            imem_req  <= req_next;
            rs1       <= rs1_next;
            rs2       <= rs2_next;
            rw        <= rw_next;
            operation <= operation_next;
            write     <= write_next;
            halted    <= halted_next;
        end
    end

`ifdef FETCH_DECODE_RETIRE_CNT_EN
    // Counts every EXEC and BRANCH cycle, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (state == ST_EXEC || state == ST_BRANCH) begin
            retire_count <= retire_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Randomized bench for fetch_decode: the bench plays instruction memory and
// predicts control outputs and PC from the instruction kinds it generates.
module tb_fetch_decode;
    import fetch_decode_pkg::*;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_DIV = 4;
    localparam int K_BEQ = 5, K_ADDI = 6, K_MUL = 7, K_BNE = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [4:0]  rs1, rs2, rw, operation;
    logic        write;
    logic        zero_flag;
    logic [31:0] pc;
    logic        halted;
`ifdef FETCH_DECODE_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    bit          exp_halted;
    int unsigned exp_retire;

    fetch_decode dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rw         (rw),
        .operation  (operation),
        .write      (write),
        .zero_flag  (zero_flag),
        .pc         (pc),
        .halted     (halted)
`ifdef FETCH_DECODE_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int kind, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb,
                                        input int off);
        logic [12:0] im;
        im = 13'(off);
        case (kind)
            K_ADD:   return {7'b0000000, rb, ra, 3'b000, rd, 7'b0110011};
            K_SUB:   return {7'b0100000, rb, ra, 3'b000, rd, 7'b0110011};
            K_AND:   return {7'b0000000, rb, ra, 3'b111, rd, 7'b0110011};
            K_OR:    return {7'b0000000, rb, ra, 3'b110, rd, 7'b0110011};
            K_DIV:   return {7'b0000001, rb, ra, 3'b100, rd, 7'b0110011};
            K_MUL:   return {7'b0000001, rb, ra, 3'b000, rd, 7'b0110011};
            K_BEQ:   return {im[12], im[10:5], rb, ra, 3'b000, im[4:1], im[11], 7'b1100011};
            K_BNE:   return {im[12], im[10:5], rb, ra, 3'b001, im[4:1], im[11], 7'b1100011};
            default: return {12'(off), ra, 3'b000, rd, 7'b0010011};
        endcase
    endfunction

    function automatic logic [4:0] exp_op(input int kind);
        case (kind)
            K_SUB:   return ALU_SUB;
            K_AND:   return ALU_AND;
            K_OR:    return ALU_OR;
            K_DIV:   return ALU_DIV;
            K_BEQ:   return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    task automatic check_retire(input string tag);
`ifdef FETCH_DECODE_RETIRE_CNT_EN
        check(tag, retire_count, exp_retire);
`else
        if (tag.len() == 0) $display("retire %0d", exp_retire);
`endif
    endtask

    task automatic reset_dut();
        reset      = 1'b0;
        imem_valid = 1'b0;
        zero_flag  = 1'b0;
        imem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_regs", {17'd0, rs1, rs2, rw}, 32'd0);
        check("rst_op", 32'(operation), 32'(ALU_ADD));
        exp_pc     = 32'h0;
        exp_halted = 1'b0;
        exp_retire = 0;
        check_retire("rst_retire");
        reset = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One instruction from fetch request through its execute/branch cycle
    task automatic issue(input int kind, input logic [4:0] rd, input logic [4:0] ra,
                         input logic [4:0] rb, input int off, input int waits, input bit zf);
        logic [31:0] w;
        logic [31:0] tgt;
        bit          ok;
        w = enc(kind, rd, ra, rb, off);
        wait_req(ok);
        if (!ok) begin
            check("req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        check("imem_addr", imem_addr, exp_pc);
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom();
            @(negedge clk);
            check("req_held", 32'(imem_req), 32'd1);
        end
        imem_rdata = w;
        imem_valid = 1'b1;
        @(negedge clk);
        imem_valid = 1'($urandom_range(0, 1));
        imem_rdata = $urandom();
        check("write_decode", 32'(write), 32'd0);
        @(negedge clk);
        imem_valid = 1'b0;
        if (kind == K_ADDI || kind == K_MUL || kind == K_BNE) begin
            check("illegal_halted", 32'(halted), 32'd1);
            check("illegal_req", 32'(imem_req), 32'd0);
            exp_halted = 1'b1;
            return;
        end
        check("rs1", 32'(rs1), 32'(ra));
        check("rs2", 32'(rs2), 32'(rb));
        check("op", 32'(operation), 32'(exp_op(kind)));
        exp_retire++;
        if (kind == K_BEQ) begin
            check("rw_beq", 32'(rw), 32'({off[4:1], off[11]}));
            check("write_beq", 32'(write), 32'd0);
            zero_flag = zf;
            @(negedge clk);
            zero_flag = 1'($urandom_range(0, 1));
            tgt = exp_pc + 32'(off);
            if (!zf) begin
                exp_pc = exp_pc + 32'd4;
            end else if (tgt[1]) begin
                check("misalign_halted", 32'(halted), 32'd1);
                check("misalign_pc", pc, exp_pc);
                exp_halted = 1'b1;
            end else begin
                exp_pc = tgt;
            end
            check("write_after_beq", 32'(write), 32'd0);
        end else begin
            check("rw", 32'(rw), 32'(rd));
            check("write_exec", 32'(write), 32'(rd != 5'd0));
            zero_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_pc = exp_pc + 32'd4;
            check("write_pulse", 32'(write), 32'd0);
            check("pc_exec", pc, exp_pc);
        end
    endtask

    task automatic check_halt_frozen(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = $urandom();
            @(negedge clk);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", pc, exp_pc);
            check("halt_flag", 32'(halted), 32'd1);
        end
        imem_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, r, off;
        bit ok;
        reset_dut();

        // Directed sequence
        issue(K_ADD, 5'd3, 5'd1, 5'd2, 0, 0, 1'b0);
        issue(K_SUB, 5'd5, 5'd6, 5'd7, 0, 3, 1'b0);
        issue(K_ADD, 5'd0, 5'd1, 5'd2, 0, 1, 1'b0);
        issue(K_OR,  5'd9, 5'd4, 5'd8, 0, 0, 1'b0);
        issue(K_BEQ, 5'd0, 5'd1, 5'd2, 8, 0, 1'b1);
        issue(K_BEQ, 5'd0, 5'd1, 5'd2, 8, 2, 1'b0);
        check_retire("retire_six");
        issue(K_ADDI, 5'd0, 5'd0, 5'd0, 0, 0, 1'b0);
        check_halt_frozen(20);
        check_retire("retire_halt");
        reset_dut();

        // Reset during a fetch wait, with a stale response around release
        wait_req(ok);
        check("mid_req", 32'(imem_req), 32'd1);
        @(negedge clk);
        reset      = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = enc(K_ADD, 5'd1, 5'd1, 5'd1, 0);
        @(negedge clk);
        check("mid_rst_req", 32'(imem_req), 32'd0);
        check("mid_rst_pc", pc, 32'h0);
        reset      = 1'b1;
        imem_rdata = enc(K_DIV, 5'd2, 5'd2, 5'd2, 0);
        @(negedge clk);
        imem_valid = 1'b0;
        exp_pc     = 32'h0;
        exp_retire = 0;
        issue(K_AND, 5'd10, 5'd11, 5'd12, 0, 1, 1'b0);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      kind = int'($urandom_range(K_ADD, K_DIV));
            else if (r < 95) kind = K_BEQ;
            else             kind = int'($urandom_range(K_ADDI, K_BNE));
            off = (int'($urandom_range(0, 64)) - 32) * 4;
            if ($urandom_range(0, 9) == 0) off = off + 2;
            issue(kind, 5'($urandom()), 5'($urandom()), 5'($urandom()), off,
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (exp_halted) begin
                check_halt_frozen(3);
                check_retire("retire_rand");
                reset_dut();
            end
        end
        check_retire("retire_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
